controle_alarme: RTL and testbench

Arm/disarm controller for the residential security system, directly downstream of the synchronous decade counter. It consumes a one-second tick, a one-cycle pulse generated when the upstream decade counter wraps 9→0. It runs exit-delay, entry-delay and siren-timeout countdowns as two BCD digits that drive the seven-segment display path. It also latches which sensor zones tripped the alarm.

---
 rtl/controle_alarme.sv | 146 ++++++++++++++
 tb/tb_controle_alarme.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/controle_alarme.sv
// Arm/disarm controller: exit, entry and siren countdowns held as two BCD digits,
// driven by a one-second tick, with a sticky record of the zones that tripped.
module controle_alarme #(
  parameter int EXIT_DELAY  = 30,
  parameter int ENTRY_DELAY = 15,
  parameter int SIREN_TIME  = 60
) (
  input  logic       clk,
  input  logic       clear,
  input  logic       tick,
  input  logic       arm,
  input  logic       disarm,
  input  logic [3:0] sensor,
  output logic [2:0] estado,
  output logic [3:0] dez,
  output logic [3:0] uni,
  output logic       sirene,
  output logic       led_armado,
  output logic [3:0] zona
);

  localparam logic [2:0] S_DESARMADO = 3'd0;
  localparam logic [2:0] S_SAIDA     = 3'd1;
  localparam logic [2:0] S_ARMADO    = 3'd2;
  localparam logic [2:0] S_ENTRADA   = 3'd3;
  localparam logic [2:0] S_DISPARADO = 3'd4;

  localparam logic [3:0] EXIT_DEZ  = 4'(EXIT_DELAY / 10);
  localparam logic [3:0] EXIT_UNI  = 4'(EXIT_DELAY % 10);
  localparam logic [3:0] ENTRY_DEZ = 4'(ENTRY_DELAY / 10);
  localparam logic [3:0] ENTRY_UNI = 4'(ENTRY_DELAY % 10);
  localparam logic [3:0] SIREN_DEZ = 4'(SIREN_TIME / 10);
  localparam logic [3:0] SIREN_UNI = 4'(SIREN_TIME % 10);

  logic [2:0] state_q, state_d;
  logic [3:0] dez_q, dez_d;
  logic [3:0] uni_q, uni_d;
  logic [3:0] zona_q, zona_d;

  logic       expire;
  logic [3:0] dez_dec, uni_dec;

  // A countdown expires on the tick that would take it from 01 to 00.
  assign expire  = tick && (dez_q == 4'd0) && (uni_q == 4'd1);
  assign uni_dec = (uni_q == 4'd0) ? 4'd9 : uni_q - 4'd1;
  assign dez_dec = (uni_q == 4'd0) ? dez_q - 4'd1 : dez_q;

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q <= S_DESARMADO;
      dez_q   <= 4'd0;
      uni_q   <= 4'd0;
      zona_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      dez_q   <= dez_d;
      uni_q   <= uni_d;
      zona_q  <= zona_d;
    end
  end

  always_comb begin
    state_d = state_q;
    dez_d   = dez_q;
    uni_d   = uni_q;
    zona_d  = zona_q;
    if (disarm && (state_q inside {S_SAIDA, S_ARMADO, S_ENTRADA, S_DISPARADO})) begin
      state_d = S_DESARMADO;
      dez_d   = 4'd0;
      uni_d   = 4'd0;
      zona_d  = 4'd0;
    end else begin
      case (state_q)
        S_DESARMADO: begin
          dez_d  = 4'd0;
          uni_d  = 4'd0;
          zona_d = 4'd0;
          if (arm && (sensor == 4'd0)) begin
            state_d = S_SAIDA;
            dez_d   = EXIT_DEZ;
            uni_d   = EXIT_UNI;
          end
        end
        S_SAIDA: begin
          if (expire) begin
            state_d = S_ARMADO;
            dez_d   = 4'd0;
            uni_d   = 4'd0;
          end else if (tick) begin
            dez_d = dez_dec;
            uni_d = uni_dec;
          end
        end
        S_ARMADO: begin
          dez_d = 4'd0;
          uni_d = 4'd0;
          if (sensor != 4'd0) begin
            state_d = S_ENTRADA;
            dez_d   = ENTRY_DEZ;
            uni_d   = ENTRY_UNI;
            zona_d  = zona_q | sensor;
          end
        end
        S_ENTRADA: begin
          zona_d = zona_q | sensor;
          if (expire) begin
            state_d = S_DISPARADO;
            dez_d   = SIREN_DEZ;
            uni_d   = SIREN_UNI;
          end else if (tick) begin
            dez_d = dez_dec;
            uni_d = uni_dec;
          end
        end
        S_DISPARADO: begin
          zona_d = zona_q | sensor;
          if (expire) begin
            state_d = S_ARMADO;
            dez_d   = 4'd0;
            uni_d   = 4'd0;
          end else if (tick) begin
            dez_d = dez_dec;
            uni_d = uni_dec;
          end
        end
        default: begin
          state_d = S_DESARMADO;
          dez_d   = 4'd0;
          uni_d   = 4'd0;
          zona_d  = 4'd0;
        end
      endcase
    end
  end

  // Indicators decode registered state only, so no input reaches an output combinationally.
  always_comb begin
    estado     = state_q;
    dez        = dez_q;
    uni        = uni_q;
    zona       = zona_q;
    sirene     = (state_q == S_DISPARADO);
    led_armado = (state_q == S_ARMADO) || (state_q == S_ENTRADA) || (state_q == S_DISPARADO);
  end

endmodule

// File: tb/tb_controle_alarme.sv
// Bench for controle_alarme: two instances (exit delay 3 and 12) share one stimulus
// stream; a decimal-count reference model feeds an expected queue drained by a monitor.
module tb_controle_alarme;

  logic       clk = 1'b0;
  logic       clear = 1'b0, tick = 1'b0, arm = 1'b0, disarm = 1'b0;
  logic [3:0] sensor = 4'd0;

  logic [2:0] estado_a, estado_b;
  logic [3:0] dez_a, dez_b, uni_a, uni_b, zona_a, zona_b;
  logic       sirene_a, sirene_b, led_a, led_b;

  int n_checks = 0;
  int n_fail   = 0;

  logic [33:0] exp_q[$];

  // Reference model: state number, plain decimal count, accumulated zones.
  int         m_st[2];
  int         m_cnt[2];
  logic [3:0] m_z[2];
  int         exit_p[2] = '{3, 12};
  int         entry_p = 2;
  int         siren_p = 4;

  always #5 clk = ~clk;

  controle_alarme #(.EXIT_DELAY(3), .ENTRY_DELAY(2), .SIREN_TIME(4)) dut_a (
    .clk(clk), .clear(clear), .tick(tick), .arm(arm), .disarm(disarm), .sensor(sensor),
    .estado(estado_a), .dez(dez_a), .uni(uni_a), .sirene(sirene_a),
    .led_armado(led_a), .zona(zona_a)
  );

  controle_alarme #(.EXIT_DELAY(12), .ENTRY_DELAY(2), .SIREN_TIME(4)) dut_b (
    .clk(clk), .clear(clear), .tick(tick), .arm(arm), .disarm(disarm), .sensor(sensor),
    .estado(estado_b), .dez(dez_b), .uni(uni_b), .sirene(sirene_b),
    .led_armado(led_b), .zona(zona_b)
  );

  function automatic logic [16:0] pack_exp(input int st, input int cnt, input logic [3:0] z);
    logic sir, led;
    sir = (st == 4);
    led = (st == 2) || (st == 3) || (st == 4);
    return {3'(st), 4'(cnt / 10), 4'(cnt % 10), sir, led, z};
  endfunction

  task automatic model_step(input int i, input logic c, input logic t, input logic a,
                            input logic d, input logic [3:0] s);
    if (c) begin
      m_st[i] = 0; m_cnt[i] = 0; m_z[i] = 4'd0;
    end else if (d && m_st[i] != 0) begin
      m_st[i] = 0; m_cnt[i] = 0; m_z[i] = 4'd0;
    end else begin
      if (m_st[i] >= 3) m_z[i] = m_z[i] | s;
      if (m_st[i] == 0) begin
        if (a && s == 4'd0) begin m_st[i] = 1; m_cnt[i] = exit_p[i]; end
      end else if (m_st[i] == 2) begin
        if (s != 4'd0) begin m_st[i] = 3; m_cnt[i] = entry_p; m_z[i] = m_z[i] | s; end
      end else if (t) begin
        if (m_cnt[i] > 1) m_cnt[i] = m_cnt[i] - 1;
        else if (m_st[i] == 1) begin m_st[i] = 2; m_cnt[i] = 0; end
        else if (m_st[i] == 3) begin m_st[i] = 4; m_cnt[i] = siren_p; end
        else begin m_st[i] = 2; m_cnt[i] = 0; end
      end
    end
  endtask

  task automatic step(input logic c, input logic t, input logic a, input logic d,
                      input logic [3:0] s);
    @(negedge clk);
    clear = c; tick = t; arm = a; disarm = d; sensor = s;
    for (int i = 0; i < 2; i++) model_step(i, c, t, a, d, s);
    exp_q.push_back({pack_exp(m_st[0], m_cnt[0], m_z[0]), pack_exp(m_st[1], m_cnt[1], m_z[1])});
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
  endtask

  task automatic tick_n(input int n);
    for (int k = 0; k < n; k++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
      idle();
    end
  endtask

  task automatic check(input string name, input logic [16:0] act, input logic [16:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t: got estado=%0d count=%0h/%0h sirene=%b led=%b zona=%b, expected estado=%0d count=%0h/%0h sirene=%b led=%b zona=%b",
               name, $time, act[16:14], act[13:10], act[9:6], act[5], act[4], act[3:0],
               exp[16:14], exp[13:10], exp[9:6], exp[5], exp[4], exp[3:0]);
    end
  endtask

  always @(posedge clk) begin
    logic [33:0] e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("dut_a", {estado_a, dez_a, uni_a, sirene_a, led_a, zona_a}, e[33:17]);
      check("dut_b", {estado_b, dez_b, uni_b, sirene_b, led_b, zona_b}, e[16:0]);
    end
  end

  initial begin
    logic pt, pa, t, a, d, c;
    logic [3:0] s;
    for (int i = 0; i < 2; i++) begin m_st[i] = 0; m_cnt[i] = 0; m_z[i] = 4'd0; end

    // Reset with random companions
    for (int k = 0; k < 2; k++)
      step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
    idle();

    // Blocked arm, then arm path, trip and alarm
    step(1'b0, 1'b0, 1'b1, 1'b0, 4'b0010);
    idle();
    step(1'b0, 1'b0, 1'b1, 1'b0, 4'b0000);
    idle();
    tick_n(3);
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'b0100);
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'b0001);
    idle();
    tick_n(2);
    tick_n(4);
    idle();

    // Disarm racing expiry in the entry delay
    step(1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    tick_n(3);
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'b1000);
    tick_n(1);
    step(1'b0, 1'b1, 1'b0, 1'b1, 4'd0);
    idle();

    // Sensor and disarm together while armed
    step(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    tick_n(3);
    step(1'b0, 1'b0, 1'b0, 1'b1, 4'b0110);
    idle();

    // BCD borrow on the 12-tick instance, then clear at 09
    step(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    tick_n(3);
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    idle();

    // Random traffic; tick and arm never held for two cycles
    pt = 1'b0; pa = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      t = !pt && ($urandom_range(0, 2) == 0);
      a = !pa && ($urandom_range(0, 7) == 0);
      d = ($urandom_range(0, 39) == 0);
      c = ($urandom_range(0, 299) == 0);
      s = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
      step(c, t, a, d, s);
      pt = t; pa = a;
    end

    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
